// File: rtl/pipe_run_ctrl_if.sv
// Control/status bundle between a run/halt sequencer and the board or bench driving it.
interface pipe_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             i_cmd_run;
    logic             i_cmd_halt;
    logic             i_cmd_step;
    logic             i_cnt_clr;
    logic [31:0]      i_if_instr;
    logic             i_wb_insn_vld;
    logic             o_fetch_en;
    logic [2:0]       o_state;
    logic             o_halted;
    logic             o_done;
    logic [CNT_W-1:0] o_cycle_cnt;
    logic [CNT_W-1:0] o_retire_cnt;
    logic [CNT_W-1:0] o_bubble_cnt;

    modport master (
        output i_cmd_run, i_cmd_halt, i_cmd_step, i_cnt_clr, i_if_instr, i_wb_insn_vld,
        input  o_fetch_en, o_state, o_halted, o_done, o_cycle_cnt, o_retire_cnt, o_bubble_cnt
    );

    modport slave (
        input  i_cmd_run, i_cmd_halt, i_cmd_step, i_cnt_clr, i_if_instr, i_wb_insn_vld,
        output o_fetch_en, o_state, o_halted, o_done, o_cycle_cnt, o_retire_cnt, o_bubble_cnt
    );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run/halt/step sequencer gating instruction fetch, with halt-instruction drain.
// Define PIPE_RUN_CTRL_PERF_CNT_EN to build the cycle/retire/bubble counters.
module pipe_run_ctrl #(
    parameter logic [31:0] HALT_INSN = 32'h0000006f,
    parameter int          DRAIN_CYC = 4,
    parameter int          CNT_W     = 32
) (
    input logic            i_clk,
    input logic            i_rstn,
    pipe_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

    state_t     state_reg, state_next;
    logic [3:0] drain_reg, drain_next;
    logic       fetch_en_reg, halted_reg, done_reg;

    // bit 0 = halt, bit 1 = run, bit 2 = step
    logic [2:0] cmd, cmd_prev_reg, cmd_edge;
    logic       halt_edge, run_edge, step_edge;

    assign cmd       = {bus.i_cmd_step, bus.i_cmd_run, bus.i_cmd_halt};
    assign cmd_edge  = cmd & ~cmd_prev_reg;
    assign halt_edge = cmd_edge[0];
    assign run_edge  = cmd_edge[1];
    assign step_edge = cmd_edge[2];

    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        case (state_reg)
            IDLE: begin
                if (halt_edge)      state_next = HALTED;
                else if (run_edge)  state_next = RUN;
                else if (step_edge) state_next = STEP;
            end
            RUN: begin
                if (bus.i_if_instr == HALT_INSN || halt_edge) begin
                    state_next = DRAIN;
                    drain_next = DRAIN_LOAD;
                end
            end
            STEP: begin
                state_next = DRAIN;
                drain_next = DRAIN_LOAD;
            end
            DRAIN: begin
                if (drain_reg == 4'd0) state_next = HALTED;
                else                   drain_next = drain_reg - 4'd1;
            end
            HALTED: begin
                if (run_edge)       state_next = RUN;
                else if (step_edge) state_next = STEP;
            end
            default: begin
                state_next = IDLE;
                drain_next = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change together with o_state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= IDLE;
            drain_reg    <= 4'd0;
            cmd_prev_reg <= 3'b000;
            fetch_en_reg <= 1'b0;
            halted_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            drain_reg    <= drain_next;
            cmd_prev_reg <= cmd;
            fetch_en_reg <= (state_next == RUN) || (state_next == STEP);
            halted_reg   <= (state_next == HALTED);
            done_reg     <= (state_next == HALTED) && (state_reg != HALTED);
        end
    end

    assign bus.o_state    = state_reg;
    assign bus.o_fetch_en = fetch_en_reg;
    assign bus.o_halted   = halted_reg;
    assign bus.o_done     = done_reg;

`ifdef PIPE_RUN_CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             active;
    logic [CNT_W-1:0] cycle_cnt_reg, retire_cnt_reg, bubble_cnt_reg;

    assign active = (state_reg == RUN) || (state_reg == STEP) || (state_reg == DRAIN);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cycle_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
            bubble_cnt_reg <= '0;
        end else if (bus.i_cnt_clr) begin
            cycle_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (active && cycle_cnt_reg != CNT_MAX)
                cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (bus.i_wb_insn_vld && retire_cnt_reg != CNT_MAX)
                retire_cnt_reg <= retire_cnt_reg + 1'b1;
            if (active && !bus.i_wb_insn_vld && bubble_cnt_reg != CNT_MAX)
                bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end
    end

    assign bus.o_cycle_cnt  = cycle_cnt_reg;
    assign bus.o_retire_cnt = retire_cnt_reg;
    assign bus.o_bubble_cnt = bubble_cnt_reg;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = bus.i_cnt_clr ^ bus.i_wb_insn_vld;

    assign bus.o_cycle_cnt  = '0;
    assign bus.o_retire_cnt = '0;
    assign bus.o_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: run/halt drain, step, edge priority, async reset, counters.
module tb_pipe_run_ctrl;
    localparam int CNT_W = 4;
`ifdef PIPE_RUN_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_run_ctrl #(
        .HALT_INSN (32'h0000006f),
        .DRAIN_CYC (4),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [2:0] st, input logic fe,
                           input logic hl, input logic dn);
        check({tag, ".state"},  32'(bus.o_state),    32'(st));
        check({tag, ".fetch"},  32'(bus.o_fetch_en), 32'(fe));
        check({tag, ".halted"}, 32'(bus.o_halted),   32'(hl));
        check({tag, ".done"},   32'(bus.o_done),     32'(dn));
    endtask

    task automatic chk_cnt(input string tag, input int cyc, input int ret, input int bub);
        check({tag, ".cycle"},  32'(bus.o_cycle_cnt),  PERF ? 32'(cyc) : 32'd0);
        check({tag, ".retire"}, 32'(bus.o_retire_cnt), PERF ? 32'(ret) : 32'd0);
        check({tag, ".bubble"}, 32'(bus.o_bubble_cnt), PERF ? 32'(bub) : 32'd0);
    endtask

    initial begin
        bus.i_cmd_run     = 1'b1;
        bus.i_cmd_halt    = 1'b0;
        bus.i_cmd_step    = 1'b0;
        bus.i_cnt_clr     = 1'b0;
        bus.i_if_instr    = 32'h00000013;
        bus.i_wb_insn_vld = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk_ctl("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        chk_cnt("reset", 0, 0, 0);
        #1 rstn = 1'b1;

        // Run held through reset -> one edge on first clock
        tick();
        chk_ctl("run_start", 3'd1, 1'b1, 1'b0, 1'b0);
        bus.i_if_instr = 32'h0000006f;
        tick();
        chk_ctl("halt_insn_drain1", 3'd3, 1'b0, 1'b0, 1'b0);
        bus.i_if_instr = 32'h00000013;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk_ctl($sformatf("run_drain%0d", i), 3'd3, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_ctl("run_halted", 3'd4, 1'b0, 1'b1, 1'b1);
        tick();
        chk_ctl("run_halted2", 3'd4, 1'b0, 1'b1, 1'b0);

        // Single step from HALTED, with run pulses during drain
        bus.i_cmd_run  = 1'b0;
        bus.i_cmd_step = 1'b1;
        tick();
        chk_ctl("step", 3'd2, 1'b1, 1'b0, 1'b0);
        bus.i_cmd_step = 1'b0;
        tick();
        chk_ctl("step_drain1", 3'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            bus.i_cmd_run = (i % 2 == 0);
            tick();
            chk_ctl($sformatf("step_drain%0d", i), 3'd3, 1'b0, 1'b0, 1'b0);
        end
        bus.i_cmd_run = 1'b0;
        tick();
        chk_ctl("step_halted", 3'd4, 1'b0, 1'b1, 1'b1);
        tick();
        chk_ctl("step_halted2", 3'd4, 1'b0, 1'b1, 1'b0);

        // Run and halt edges together in IDLE -> straight to HALTED
        rstn = 1'b0;
        #1 rstn = 1'b1;
        check("idle_after_rst", 32'(bus.o_state), 32'd0);
        bus.i_cmd_run  = 1'b1;
        bus.i_cmd_halt = 1'b1;
        tick();
        chk_ctl("prio_halted", 3'd4, 1'b0, 1'b1, 1'b1);
        bus.i_cmd_run  = 1'b0;
        bus.i_cmd_halt = 1'b0;
        tick();
        chk_ctl("prio_halted2", 3'd4, 1'b0, 1'b1, 1'b0);

        // Async reset in the middle of DRAIN
        bus.i_cmd_step = 1'b1;
        tick();
        chk_ctl("rst_step", 3'd2, 1'b1, 1'b0, 1'b0);
        bus.i_cmd_step = 1'b0;
        tick();
        tick();
        chk_ctl("rst_drain", 3'd3, 1'b0, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk_ctl("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl($sformatf("idle_hold%0d", i), 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // Counters over 20 RUN cycles, wb valid toggling from 1
        bus.i_cmd_run = 1'b1;
        tick();
        chk_ctl("cnt_run", 3'd1, 1'b1, 1'b0, 1'b0);
        chk_cnt("cnt_start", 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            bus.i_wb_insn_vld = (i % 2 == 0);
            tick();
        end
        chk_cnt("cnt_20", 15, 10, 10);
        bus.i_wb_insn_vld = 1'b0;
        bus.i_cnt_clr     = 1'b1;
        tick();
        chk_cnt("cnt_clr", 0, 0, 0);
        bus.i_cnt_clr = 1'b0;
        tick();
        chk_cnt("cnt_after_clr", 1, 0, 1);
        chk_ctl("cnt_still_run", 3'd1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
